command_encoder: RTL and testbench

Transmit-side counterpart of `control_module`. It accepts high-level requests (set brightness, load one row) and serializes them into the same byte-level command stream that `control_module` parses. For a row load it reads the row payload from a synchronous byte-wide read port. It sits ahead of a byte transmitter (`uart_tx` or an SPI master) in a host-emulation or loop-back path.

---
 rtl/params_pkg.sv | 25 ++
 rtl/command_encoder.sv | 112 +++++++++++
 tb/tb_command_encoder.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/params_pkg.sv
// Shared constants and types for the command stream between command_encoder
// and control_module.
package params_pkg;

    localparam logic [7:0] CMD_BRIGHTNESS = 8'h62;  // 'b'
    localparam logic [7:0] CMD_ROW_LOAD   = 8'h4C;  // 'L'

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_OP,
        ST_SEND_ARG,
        ST_READ,
        ST_WAIT_RD,
        ST_SEND_DATA
    } cmd_enc_state_t;

    function automatic logic [7:0] opcode_for(input logic op);
        return op ? CMD_ROW_LOAD : CMD_BRIGHTNESS;
    endfunction

    function automatic logic is_send_state(input cmd_enc_state_t st);
        return (st == ST_SEND_OP) || (st == ST_SEND_ARG) || (st == ST_SEND_DATA);
    endfunction

endpackage

// File: rtl/command_encoder.sv
// Serializes brightness / row-load requests into the byte stream parsed by
// control_module; row payloads are fetched highest column first.
module command_encoder
    import params_pkg::*;
#(
    parameter int ROW_BYTES = 128,
    parameter int COL_BITS  = $clog2(ROW_BYTES)
) (
    input  logic                clk_in,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_op,
    input  logic [7:0]          req_arg,
    output logic [7:0]          rd_row,
    output logic [COL_BITS-1:0] rd_addr,
    output logic                rd_en,
    input  logic [7:0]          rd_data,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                busy,
    output logic [7:0]          commands_sent
);

    localparam logic [COL_BITS-1:0] COL_MAX = COL_BITS'(ROW_BYTES - 1);

    cmd_enc_state_t      state_q, state_d;
    logic                op_q;
    logic [7:0]          arg_q;
    logic [COL_BITS-1:0] col_q;
    logic [7:0]          tx_data_q;
    logic                tx_valid_q;
    logic [7:0]          cmd_cnt_q;

    logic accept;
    logic tx_hs;

    assign accept = req_valid & req_ready;
    assign tx_hs  = tx_valid_q & tx_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:      if (req_valid) state_d = ST_SEND_OP;
            ST_SEND_OP:   if (tx_hs) state_d = ST_SEND_ARG;
            ST_SEND_ARG:  if (tx_hs) state_d = op_q ? ST_READ : ST_IDLE;
            ST_READ:      state_d = ST_WAIT_RD;
            ST_WAIT_RD:   state_d = ST_SEND_DATA;
            ST_SEND_DATA: if (tx_hs) state_d = (col_q == '0) ? ST_IDLE : ST_READ;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == ST_IDLE);
        busy      = (state_q != ST_IDLE);
        rd_en     = (state_q == ST_READ);
    end

    // tx_valid is registered from the next state so it is glitch-free and
    // high exactly in the three send states.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            op_q       <= 1'b0;
            arg_q      <= 8'h00;
            col_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            cmd_cnt_q  <= 8'h00;
        end else begin
            tx_valid_q <= is_send_state(state_d);

            if (accept) begin
                op_q      <= req_op;
                arg_q     <= req_arg;
                col_q     <= COL_MAX;
                tx_data_q <= opcode_for(req_op);
            end

            if (state_q == ST_SEND_OP && tx_hs)
                tx_data_q <= arg_q;

            if (state_q == ST_WAIT_RD)
                tx_data_q <= rd_data;

            if (state_q == ST_SEND_ARG && tx_hs && !op_q)
                cmd_cnt_q <= cmd_cnt_q + 8'd1;

            if (state_q == ST_SEND_DATA && tx_hs) begin
                if (col_q == '0) cmd_cnt_q <= cmd_cnt_q + 8'd1;
                else             col_q     <= col_q - 1'b1;
            end
        end
    end

    assign rd_row        = arg_q;
    assign rd_addr       = col_q;
    assign tx_data       = tx_data_q;
    assign tx_valid      = tx_valid_q;
    assign commands_sent = cmd_cnt_q;

endmodule

// File: tb/tb_command_encoder.sv
// Scoreboard bench for command_encoder with ROW_BYTES = 4: stimulus pushes
// expected bytes/reads, a negedge monitor pops and compares them.
module tb_command_encoder;

    localparam int ROW_BYTES = 4;
    localparam int COL_BITS  = 2;

    typedef struct {
        logic [7:0] data;
        bit         payload;
    } exp_byte_t;

    typedef struct {
        logic [7:0]          row;
        logic [COL_BITS-1:0] addr;
    } exp_rd_t;

    logic                clk_in = 1'b0;
    logic                reset_n = 1'b0;
    logic                req_valid = 1'b0;
    logic                req_ready;
    logic                req_op = 1'b0;
    logic [7:0]          req_arg = 8'h00;
    logic [7:0]          rd_row;
    logic [COL_BITS-1:0] rd_addr;
    logic                rd_en;
    logic [7:0]          rd_data = 8'h00;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                tx_ready = 1'b1;
    logic                busy;
    logic [7:0]          commands_sent;

    int total = 0;
    int bad   = 0;

    exp_byte_t exp_q[$];
    exp_rd_t   rd_q[$];
    logic [7:0] mem [ROW_BYTES];
    logic [7:0] exp_cnt = 8'h00;

    bit         stall_mode = 1'b0;
    int         stall_cnt = 0;
    bit         was_stalled = 1'b0;
    logic [7:0] held_data = 8'h00;
    int         payload_hs = 0;

    command_encoder #(.ROW_BYTES(ROW_BYTES), .COL_BITS(COL_BITS)) dut (
        .clk_in        (clk_in),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_arg       (req_arg),
        .rd_row        (rd_row),
        .rd_addr       (rd_addr),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .busy          (busy),
        .commands_sent (commands_sent)
    );

    always #5 clk_in = ~clk_in;

    // Synchronous payload memory: data appears one cycle after rd_en.
    always @(posedge clk_in) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: unexpected value 0x%0h at %0t", name, act, $time);
    endtask

    // Monitor: compares handshaken bytes and read strobes, checks stall hold,
    // and drives tx_ready for the next cycle.
    always @(negedge clk_in) begin
        automatic bit hs = tx_valid && tx_ready;
        if (tx_valid && !tx_ready) begin
            if (was_stalled) check("tx_data_hold", tx_data, held_data);
            held_data   = tx_data;
            was_stalled = 1'b1;
            stall_cnt++;
        end else begin
            was_stalled = 1'b0;
        end
        if (hs) begin
            if (exp_q.size() == 0) begin
                flag("tx_extra_byte", tx_data);
            end else begin
                automatic exp_byte_t e = exp_q.pop_front();
                check("tx_byte", tx_data, e.data);
                if (e.payload) payload_hs++;
            end
            stall_cnt = 0;
        end
        if (rd_en) begin
            if (rd_q.size() == 0) begin
                flag("rd_extra", rd_addr);
            end else begin
                automatic exp_rd_t r = rd_q.pop_front();
                check("rd_addr", rd_addr, r.addr);
                check("rd_row", rd_row, r.row);
            end
        end
        tx_ready = !(stall_mode && exp_q.size() > 0 && exp_q[0].payload && stall_cnt < 5);
    end

    task automatic push_byte(input logic [7:0] d, input bit p);
        exp_byte_t e;
        e.data = d;
        e.payload = p;
        exp_q.push_back(e);
    endtask

    task automatic push_rd(input logic [7:0] row, input logic [COL_BITS-1:0] addr);
        exp_rd_t r;
        r.row = row;
        r.addr = addr;
        rd_q.push_back(r);
    endtask

    task automatic issue_req(input logic op, input logic [7:0] arg);
        int n;
        @(negedge clk_in);
        req_valid = 1'b1;
        req_op    = op;
        req_arg   = arg;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        if (!req_ready) flag("req_ready_timeout", n);
        @(posedge clk_in);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int exp_cycles, input logic [7:0] cnt);
        int cyc = 1;
        while (cyc < 2000) begin
            @(negedge clk_in);
            if (!busy) break;
            cyc++;
        end
        if (busy) flag("idle_timeout", cyc);
        if (exp_cycles > 0) check("cmd_cycles", cyc, exp_cycles);
        check("frame_bytes_left", exp_q.size(), 0);
        check("commands_sent", commands_sent, cnt);
        check("req_ready_after", req_ready, 1'b1);
    endtask

    task automatic run_bright(input logic [7:0] arg);
        push_byte(8'h62, 1'b0);
        push_byte(arg, 1'b0);
        exp_cnt = exp_cnt + 8'd1;
        issue_req(1'b0, arg);
        wait_idle(3, exp_cnt);
    endtask

    task automatic push_row_frame(input logic [7:0] arg);
        push_byte(8'h4C, 1'b0);
        push_byte(arg, 1'b0);
        // mem[c] = 0x10 + c, read from column 3 down to 0
        push_byte(8'h13, 1'b1); push_rd(arg, 2'd3);
        push_byte(8'h12, 1'b1); push_rd(arg, 2'd2);
        push_byte(8'h11, 1'b1); push_rd(arg, 2'd1);
        push_byte(8'h10, 1'b1); push_rd(arg, 2'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_tx_valid"}, tx_valid, 1'b0);
        check({tag, "_tx_data"}, tx_data, 8'h00);
        check({tag, "_rd_en"}, rd_en, 1'b0);
        check({tag, "_rd_addr"}, rd_addr, 2'd0);
        check({tag, "_rd_row"}, rd_row, 8'h00);
        check({tag, "_commands_sent"}, commands_sent, 8'h00);
    endtask

    initial begin
        int base;
        int n;
        for (int c = 0; c < ROW_BYTES; c++) mem[c] = 8'h10 + 8'(c);

        #12;
        check_reset_outputs("in_reset");
        @(negedge clk_in);
        reset_n = 1'b1;
        @(negedge clk_in);
        check_reset_outputs("post_reset");

        // Brightness 0x72
        run_bright(8'h72);

        // Row load 0x2D, no backpressure: 3 + 3*ROW_BYTES cycles
        push_row_frame(8'h2D);
        exp_cnt = exp_cnt + 8'd1;
        issue_req(1'b1, 8'h2D);
        wait_idle(3 + 3 * ROW_BYTES, exp_cnt);
        check("rd_q_empty", rd_q.size(), 0);

        // Same row with 5 stall cycles per payload byte
        stall_mode = 1'b1;
        push_row_frame(8'h2D);
        exp_cnt = exp_cnt + 8'd1;
        issue_req(1'b1, 8'h2D);
        wait_idle(3 + 8 * ROW_BYTES, exp_cnt);
        check("rd_q_empty_bp", rd_q.size(), 0);
        stall_mode = 1'b0;

        // Reset after the second payload byte has been taken
        push_row_frame(8'h5A);
        base = payload_hs;
        issue_req(1'b1, 8'h5A);
        n = 0;
        while (payload_hs < base + 2 && n < 500) begin
            @(negedge clk_in);
            #1;
            n++;
        end
        if (payload_hs < base + 2) flag("payload_wait_timeout", n);
        @(posedge clk_in);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        exp_q.delete();
        rd_q.delete();
        exp_cnt = 8'h00;
        repeat (2) @(negedge clk_in);
        reset_n = 1'b1;
        run_bright(8'hA5);

        // Wrap: 256 brightness commands since reset
        for (int i = 0; i < 254; i++) run_bright(8'(i));
        check("cnt_255", commands_sent, 8'hFF);
        run_bright(8'h01);
        check("cnt_wrap", commands_sent, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
